// File: rtl/ppm_rx_frame_ctrl_if.sv
//============================================================================
// Module      : ppm_rx_frame_ctrl_if
// Description : Byte stream (valid/ready) between the PPM frame sequencer
//               and the downstream byte consumer.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface ppm_rx_frame_ctrl_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_data,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        output byte_ready
    );
endinterface

`default_nettype wire

// File: rtl/ppm_rx_frame_ctrl.sv
//============================================================================
// Module      : ppm_rx_frame_ctrl
// Description : Frame sequencer for the 1-of-4 PPM receiver: SOF/EOF framing,
//               symbol-to-byte packing, 2-entry byte FIFO, done/error report.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module ppm_rx_frame_ctrl #(
    parameter int MAX_BYTES = 32,
    parameter int TIMEOUT   = 64,
    parameter int CNT_W     = 6
) (
    input  wire logic             clk16,
    input  wire logic             rst_n,
    input  wire logic             rx_en,
    input  wire logic             sof_det,
    input  wire logic             sym_valid,
    input  wire logic [1:0]       sym_data,
    input  wire logic             eof_rcv,
    output logic                  dec_en,
    output logic                  dec_clr,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic [1:0]            err_code,
    output logic [CNT_W-1:0]      byte_cnt,
    output logic                  busy,
    ppm_rx_frame_ctrl_if.master   byte_if
);

    localparam int               TMR_W       = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] c_max_bytes = CNT_W'(MAX_BYTES);
    localparam logic [TMR_W-1:0] c_tmo_last  = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HUNT  = 3'd1,
        S_RX    = 3'd2,
        S_DRAIN = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t           r_state;
    logic [1:0]       r_sym_idx;
    logic [5:0]       r_shreg;
    logic [TMR_W-1:0] r_timer;
    logic [7:0]       r_mem [2];
    logic             r_wr;
    logic             r_rd;
    logic [1:0]       r_count;

    logic             w_sym;
    logic [1:0]       w_idx_nxt;
    logic [1:0]       w_idx_after;
    logic             w_push_req;
    logic             w_pop;
    logic             w_ovf;
    logic             w_push;
    logic [7:0]       w_push_byte;
    logic [CNT_W-1:0] w_cnt_after;
    logic             w_eof;
    logic             w_eof_ok;
    logic             w_tmo;
    logic             w_abort;
    logic             w_flush;

    assign w_sym       = (r_state == S_RX) && sym_valid;
    assign w_idx_nxt   = r_sym_idx + 2'd1;
    assign w_idx_after = w_sym ? w_idx_nxt : r_sym_idx;
    assign w_push_req  = w_sym && (r_sym_idx == 2'd3);
    assign w_pop       = (r_count != 2'd0) && byte_if.byte_ready;
    // A full FIFO only accepts the push when the head leaves in the same cycle
    assign w_ovf       = w_push_req &&
                         (((r_count == 2'd2) && !w_pop) || (byte_cnt == c_max_bytes));
    assign w_push      = w_push_req && !w_ovf && rx_en;
    assign w_push_byte = {sym_data, r_shreg};
    assign w_cnt_after = byte_cnt + CNT_W'(w_push);
    assign w_eof       = (r_state == S_RX) && eof_rcv;
    assign w_eof_ok    = (w_idx_after == 2'd0) && (w_cnt_after != '0);
    assign w_tmo       = (r_state == S_RX) && !sym_valid && !eof_rcv && (r_timer == c_tmo_last);
    assign w_abort     = rx_en && (w_ovf || (w_eof && !w_eof_ok) || w_tmo);
    assign w_flush     = !rx_en || (r_state == S_ABORT) || w_abort;

    assign byte_if.byte_valid = (r_count != 2'd0);
    assign byte_if.byte_data  = r_mem[r_rd];

    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_count  <= 2'd0;
        end else if (w_flush) begin
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= w_push_byte;
                r_wr        <= ~r_wr;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sym_idx  <= 2'd0;
            r_shreg    <= '0;
            r_timer    <= '0;
            dec_en     <= 1'b0;
            dec_clr    <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= 2'd0;
            byte_cnt   <= '0;
            busy       <= 1'b0;
        end else begin
            dec_clr    <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (!rx_en) begin
                r_state <= S_IDLE;
                dec_en  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: r_state <= S_HUNT;
                    S_HUNT: begin
                        if (sof_det) begin
                            r_state   <= S_RX;
                            dec_en    <= 1'b1;
                            dec_clr   <= 1'b1;
                            busy      <= 1'b1;
                            byte_cnt  <= '0;
                            err_code  <= 2'd0;
                            r_sym_idx <= 2'd0;
                            r_timer   <= '0;
                        end
                    end
                    S_RX: begin
                        if (w_sym) begin
                            case (r_sym_idx)
                                2'd0:    r_shreg[1:0] <= sym_data;
                                2'd1:    r_shreg[3:2] <= sym_data;
                                2'd2:    r_shreg[5:4] <= sym_data;
                                default: ;
                            endcase
                            r_sym_idx <= w_idx_nxt;
                        end
                        if (w_push) begin
                            byte_cnt <= w_cnt_after;
                        end
                        r_timer <= (sym_valid || eof_rcv) ? '0 : r_timer + 1'b1;
                        if (w_abort) begin
                            r_state   <= S_ABORT;
                            dec_en    <= 1'b0;
                            busy      <= 1'b0;
                            frame_err <= 1'b1;
                            err_code  <= w_ovf ? 2'd3 : (w_tmo ? 2'd2 : 2'd1);
                        end else if (w_eof) begin
                            r_state <= S_DRAIN;
                            dec_en  <= 1'b0;
                        end
                    end
                    S_DRAIN: begin
                        if (r_count == 2'd0) begin
                            r_state    <= S_HUNT;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end
                    end
                    S_ABORT: r_state <= S_HUNT;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ppm_rx_frame_ctrl.sv
//============================================================================
// Module      : tb_ppm_rx_frame_ctrl
// Description : Directed self-checking bench for ppm_rx_frame_ctrl.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_ppm_rx_frame_ctrl;

    localparam int TIMEOUT = 64;

    logic       clk16;
    logic       rst_n;
    logic       rx_en;
    logic       sof_det;
    logic       sym_valid;
    logic [1:0] sym_data;
    logic       eof_rcv;
    logic       dec_en;
    logic       dec_clr;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;
    logic [5:0] byte_cnt;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;

    ppm_rx_frame_ctrl_if byte_if ();

    ppm_rx_frame_ctrl #(
        .MAX_BYTES (32),
        .TIMEOUT   (TIMEOUT),
        .CNT_W     (6)
    ) dut (
        .clk16      (clk16),
        .rst_n      (rst_n),
        .rx_en      (rx_en),
        .sof_det    (sof_det),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .eof_rcv    (eof_rcv),
        .dec_en     (dec_en),
        .dec_clr    (dec_clr),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .byte_cnt   (byte_cnt),
        .busy       (busy),
        .byte_if    (byte_if.master)
    );

    logic [21:0] all_outs;
    assign all_outs = {dec_en, dec_clr, frame_done, frame_err, busy, byte_if.byte_valid,
                       err_code, byte_cnt, byte_if.byte_data};

    initial clk16 = 1'b0;
    always #5 clk16 = ~clk16;

    task automatic tick();
        @(posedge clk16);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic sof();
        sof_det = 1'b1;
        tick();
        sof_det = 1'b0;
    endtask

    task automatic sym(input logic [1:0] d);
        sym_valid = 1'b1;
        sym_data  = d;
        tick();
        sym_valid = 1'b0;
    endtask

    task automatic eof();
        eof_rcv = 1'b1;
        tick();
        eof_rcv = 1'b0;
    endtask

    initial begin
        int k;
        int early;
        rst_n = 1'b0; rx_en = 1'b0; sof_det = 1'b0; sym_valid = 1'b0;
        sym_data = 2'd0; eof_rcv = 1'b0; byte_if.byte_ready = 1'b0;
        tick(); tick();
        chk("reset_outs", 32'(all_outs), 0);
        rst_n = 1'b1;
        rx_en = 1'b1;
        tick(); tick();
        chk("idle_hunt_quiet", 32'(all_outs), 0);

        // Good frame: 2,3,0,1 -> 0x4E
        byte_if.byte_ready = 1'b1;
        sof();
        chk("sof_clr_en_busy", 32'({dec_clr, dec_en, busy}), 3'b111);
        sym(2'd2);
        chk("clr_one_cycle", 32'(dec_clr), 0);
        sym(2'd3); sym(2'd0); sym(2'd1);
        chk("good_valid", 32'(byte_if.byte_valid), 1);
        chk("good_data", 32'(byte_if.byte_data), 32'h4E);
        chk("good_cnt", 32'(byte_cnt), 1);
        eof();
        chk("drain_state", 32'({busy, dec_en, byte_if.byte_valid}), 3'b100);
        tick();
        chk("good_done", 32'({frame_done, frame_err, err_code, byte_cnt}), {1'b1, 1'b0, 2'd0, 6'd1});
        tick();
        chk("done_one_cycle", 32'(frame_done), 0);

        // Partial byte, then empty frame
        sof(); sym(2'd1); sym(2'd2); eof();
        chk("partial_err", 32'({frame_err, err_code, byte_if.byte_valid}), {1'b1, 2'd1, 1'b0});
        tick();
        chk("err_one_cycle", 32'(frame_err), 0);
        sof(); eof();
        chk("empty_err", 32'({frame_err, err_code, byte_cnt}), {1'b1, 2'd1, 6'd0});
        tick();

        // Timeout: frame_err rises TIMEOUT edges after the symbol edge
        sof(); sym(2'd3);
        k = 0;
        while (!frame_err && k < 200) begin
            tick();
            k++;
        end
        chk("timeout_latency", 32'(k), TIMEOUT);
        chk("timeout_code", 32'({err_code, dec_en, busy}), {2'd2, 1'b0, 1'b0});
        tick();

        // Backpressure overflow: third push with a full FIFO
        byte_if.byte_ready = 1'b0;
        sof();
        for (int b = 0; b < 2; b++) begin
            sym(2'd0); sym(2'd1); sym(2'd2); sym(2'd3);
        end
        chk("ovf_pre_cnt", 32'({byte_if.byte_valid, byte_cnt}), {1'b1, 6'd2});
        sym(2'd0); sym(2'd1); sym(2'd2); sym(2'd3);
        chk("ovf_err", 32'({frame_err, err_code, byte_if.byte_valid, byte_cnt}),
            {1'b1, 2'd3, 1'b0, 6'd2});
        tick();

        // Two bytes held in the FIFO for 20 cycles after EOF
        sof();
        sym(2'd3); sym(2'd2); sym(2'd1); sym(2'd0);
        sym(2'd0); sym(2'd1); sym(2'd2); sym(2'd3);
        eof();
        early = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (frame_done) early++;
        end
        chk("drain_hold", 32'(early), 0);
        chk("drain_head", 32'({busy, byte_if.byte_valid, byte_if.byte_data}), {1'b1, 1'b1, 8'h1B});
        byte_if.byte_ready = 1'b1;
        tick();
        chk("drain_second", 32'(byte_if.byte_data), 32'hE4);
        tick();
        chk("drain_not_yet", 32'(frame_done), 0);
        tick();
        chk("drain_done", 32'({frame_done, byte_cnt, err_code}), {1'b1, 6'd2, 2'd0});
        tick();

        // 4th symbol with EOF in the same cycle; SOF during RX ignored
        sof();
        sof_det = 1'b1;
        sym(2'd2);
        sof_det = 1'b0;
        chk("sof_ignored", 32'(dec_clr), 0);
        sym(2'd3); sym(2'd0);
        sym_valid = 1'b1; sym_data = 2'd1; eof_rcv = 1'b1;
        tick();
        sym_valid = 1'b0; eof_rcv = 1'b0;
        chk("sim_push", 32'({byte_if.byte_valid, byte_if.byte_data, busy, dec_en}),
            {1'b1, 8'h4E, 1'b1, 1'b0});
        tick(); tick();
        chk("sim_done", 32'({frame_done, frame_err, byte_cnt}), {1'b1, 1'b0, 6'd1});
        tick();

        // rx_en drop mid-frame
        byte_if.byte_ready = 1'b0;
        sof();
        sym(2'd0); sym(2'd0); sym(2'd0); sym(2'd0);
        sym(2'd1);
        rx_en = 1'b0;
        tick();
        chk("rxen_drop", 32'({byte_if.byte_valid, dec_en, busy, frame_done, frame_err, byte_cnt}),
            {5'b00000, 6'd1});
        tick();
        chk("rxen_quiet", 32'({frame_done, frame_err}), 0);
        rx_en = 1'b1;
        tick(); tick();

        // Asynchronous reset mid-RX
        sof();
        sym(2'd2); sym(2'd3); sym(2'd0); sym(2'd1);
        chk("pre_rst_valid", 32'(byte_if.byte_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", 32'(all_outs), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst", 32'(all_outs), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
